nios_sys_led_driver: RTL
========================

Name: nios_sys_led_driver

Overview:
- Downstream consumer of the Nios system's 4-bit LED PIO output port; sits between the PIO register and the board LED pins.
- Per-LED pulse stretching: short software pulses stay visible for a minimum on-time.
- Per-LED optional blinking.
- Global PWM brightness.
- Fully synchronous to the system clock; no bus interface. Control inputs come from other PIO outputs.

Parameters:
- WIDTH, 4, number of LED channels.
- PWM_BITS, 4, width of brightness control and PWM counter.
- PRESCALE, 50000, clk cycles per time-base tick (1 ms at 50 MHz); must be >= 2.
- STRETCH_TICKS, 100, minimum on-time in ticks after a rising edge of led_in[i]; range 1..65535.
- BLINK_TICKS, 250, ticks per blink half-period; range 1..65535.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- led_in  in  WIDTH  LED request bits from PIO out_port.
- blink_en  in  WIDTH  per-LED blink enable.
- brightness  in  PWM_BITS  global duty control.
- tick  out  1  one-cycle time-base strobe (debug/observability).
- led_out  out  WIDTH  drive to LED pins, active-high.

Behaviour:
- Reset:
  - Asynchronous, active-high. While asserted, every register is 0: led_in_r, prescaler, pwm_cnt, stretch counters, blink counter, blink_phase.
  - Outputs during and after reset: tick=0, led_out=0.
  - Reset mid-operation aborts all stretch and blink state immediately.
- Input stage:
  - led_in_r <= led_in every cycle.
  - rise[i] = led_in[i] & ~led_in_r[i].
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps to 0.
  - tick is a registered output: 1 for exactly the one cycle after the prescaler equals PRESCALE-1, so the period is PRESCALE cycles.
  - First tick occurs PRESCALE cycles after reset release.
- Stretch counter (per LED, 16 bits):
  - Priority 1: rise[i] loads STRETCH_TICKS. A rise reloads even if the counter is nonzero.
  - Priority 2: otherwise, tick with count != 0 decrements the counter.
  - A rise and a tick in the same cycle load (no decrement).
  - active[i] = led_in_r[i] | (stretch[i] != 0).
- Blink (shared):
  - Counter advances on tick.
  - When it reaches BLINK_TICKS-1 with tick, it wraps to 0 and blink_phase toggles.
  - gate[i] = ~blink_en[i] | blink_phase.
  - blink_phase=0 after reset, so blink-enabled LEDs start dark.
- PWM:
  - pwm_cnt increments every cycle, wrapping modulo 2^PWM_BITS.
  - pwm_on = (brightness == all-ones) | (pwm_cnt < brightness).
  - brightness 0: always off. All-ones: always on. Otherwise duty = brightness / 2^PWM_BITS.
  - brightness is sampled combinationally each cycle; no glitch protection is required.
- Output:
  - led_out[i] <= active[i] & gate[i] & pwm_on (registered).
  - Latency from led_in to led_out: 2 cycles. rise and active use led_in_r, with the rise comparison using led_in.
- Falling edge of led_in during stretch: LED stays on until the counter expires.
- blink_en change takes effect on the next cycle's gate; blink phase is not reset.

Test Plan:
Bench parameters: WIDTH=4, PWM_BITS=2, PRESCALE=4, STRETCH_TICKS=3, BLINK_TICKS=2.
1. Reset value:
   - Stimulus: reset=1 with led_in=4'hF, brightness=3.
   - Required: led_out=0 and tick=0 throughout.
   - Then release reset: led_out=4'hF two cycles after the first cycle with led_in sampled; tick first high 4 cycles after release, then every 4 cycles.
2. Stretch:
   - Stimulus: brightness=3, blink_en=0; pulse led_in[0]=1 for one cycle.
   - Required: led_out[0] rises 2 cycles later and stays high until the 3rd tick after the edge, plus 1 cycle; led_out[3:1]=0 throughout.
3. Reload / simultaneous:
   - Stimulus: second pulse on led_in[0] while stretch=1, aligned with a tick.
   - Required: counter reloads to 3 (not 2) and on-time extends 3 further ticks.
4. Blink:
   - Stimulus: led_in=4'b0011, blink_en=4'b0010, brightness=3.
   - Required: led_out[0] steady 1; led_out[1] toggles every 8 cycles (2 ticks), initially 0.
5. PWM:
   - Stimulus: led_in=4'h1, blink_en=0, sweep brightness 0/1/2/3.
   - Required: led_out[0] high 0, 1, 2, 4 cycles out of every 4 respectively.
6. Async reset mid-stretch:
   - Stimulus: assert reset asynchronously between clock edges during an active stretch.
   - Required: led_out=0 immediately, with no clock edge needed; after release, no residual stretch with led_in=0.

Source files
------------

// File: rtl/nios_sys_led_driver_if.sv
// nios_sys_led_driver_if
// Groups the LED driver's control and pin signals so that the PIO side
// and the driver can be wired as a single bundle.
//   led_in     : LED request bits coming from the PIO out_port
//   blink_en   : per-LED blink enable
//   brightness : global PWM duty control
//   tick       : one-cycle time-base strobe, for observability
//   led_out    : active-high drive to the board LED pins
// The master modport is the side that owns the requests (PIO / bench).
// The slave modport is the LED driver itself.
interface nios_sys_led_driver_if #(
  parameter int WIDTH    = 4,
  parameter int PWM_BITS = 4
);
  logic [WIDTH-1:0]    led_in;
  logic [WIDTH-1:0]    blink_en;
  logic [PWM_BITS-1:0] brightness;
  logic                tick;
  logic [WIDTH-1:0]    led_out;

  modport master (
    output led_in, blink_en, brightness,
    input  tick, led_out
  );

  modport slave (
    input  led_in, blink_en, brightness,
    output tick, led_out
  );
endinterface

// File: rtl/nios_sys_led_driver.sv
// nios_sys_led_driver
// Sits between the Nios LED PIO register and the board LED pins.
// It stretches short software pulses to a minimum visible on-time, lets
// each LED blink from a shared blink phase, and applies a global PWM
// brightness.
//   clk   : system clock
//   reset : asynchronous, active-high; clears every register
//   bus   : slave side of nios_sys_led_driver_if
//           (led_in, blink_en, brightness in; tick, led_out out)
module nios_sys_led_driver #(
  parameter int WIDTH         = 4,
  parameter int PWM_BITS      = 4,
  parameter int PRESCALE      = 50000,
  parameter int STRETCH_TICKS = 100,
  parameter int BLINK_TICKS   = 250
) (
  input logic                    clk,
  input logic                    reset,
  nios_sys_led_driver_if.slave   bus
);

  localparam int PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST      = PS_W'(PRESCALE - 1);
  localparam logic [15:0]     STRETCH_LOAD = 16'(STRETCH_TICKS);
  localparam logic [15:0]     BLINK_LAST   = 16'(BLINK_TICKS - 1);

  logic [WIDTH-1:0]         ledInQ;
  logic [PS_W-1:0]          prescaleQ, prescaleD;
  logic                     tickQ, tickD;
  logic [PWM_BITS-1:0]      pwmCntQ, pwmCntD;
  logic [WIDTH-1:0][15:0]   stretchQ, stretchD;
  logic [15:0]              blinkCntQ, blinkCntD;
  logic                     blinkPhaseQ, blinkPhaseD;
  logic [WIDTH-1:0]         ledOutQ, ledOutD;
  logic [WIDTH-1:0]         rise, active, gate;
  logic                     pwmOn;

  // Time base: the prescaler wraps every PRESCALE cycles and the tick
  // strobe is registered, so it appears the cycle after the last count.
  always_comb begin
    tickD     = (prescaleQ == PS_LAST);
    prescaleD = tickD ? '0 : prescaleQ + PS_W'(1);
  end

  // Pulse stretching: a fresh rising edge always (re)loads the full
  // on-time, and wins over a decrement that lands in the same cycle.
  always_comb begin
    rise     = bus.led_in & ~ledInQ;
    stretchD = stretchQ;
    active   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (rise[i]) begin
        stretchD[i] = STRETCH_LOAD;
      end else if (tickQ && (stretchQ[i] != 16'd0)) begin
        stretchD[i] = stretchQ[i] - 16'd1;
      end
      active[i] = ledInQ[i] | (stretchQ[i] != 16'd0);
    end
  end

  // Shared blink phase: toggles every BLINK_TICKS ticks and starts dark.
  always_comb begin
    blinkCntD   = blinkCntQ;
    blinkPhaseD = blinkPhaseQ;
    if (tickQ) begin
      if (blinkCntQ == BLINK_LAST) begin
        blinkCntD   = 16'd0;
        blinkPhaseD = ~blinkPhaseQ;
      end else begin
        blinkCntD = blinkCntQ + 16'd1;
      end
    end
    gate = ~bus.blink_en | {WIDTH{blinkPhaseQ}};
  end

  // PWM: full-scale brightness forces the LED permanently on so that the
  // top setting does not lose one slot per period.
  always_comb begin
    pwmCntD = pwmCntQ + PWM_BITS'(1);
    pwmOn   = (&bus.brightness) | (pwmCntQ < bus.brightness);
    ledOutD = active & gate & {WIDTH{pwmOn}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ledInQ      <= '0;
      prescaleQ   <= '0;
      tickQ       <= 1'b0;
      pwmCntQ     <= '0;
      stretchQ    <= '0;
      blinkCntQ   <= 16'd0;
      blinkPhaseQ <= 1'b0;
      ledOutQ     <= '0;
    end else begin
      ledInQ      <= bus.led_in;
      prescaleQ   <= prescaleD;
      tickQ       <= tickD;
      pwmCntQ     <= pwmCntD;
      stretchQ    <= stretchD;
      blinkCntQ   <= blinkCntD;
      blinkPhaseQ <= blinkPhaseD;
      ledOutQ     <= ledOutD;
    end
  end

  assign bus.tick    = tickQ;
  assign bus.led_out = ledOutQ;

endmodule
